// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions: FSM states and encoding length limits,
// used by both the encoder and the decoder side.
package leb128_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int LEB128_I32_MAX_BYTES = 5;
  localparam int LEB128_I64_MAX_BYTES = 10;
  localparam int LEB128_CONT_BIT      = 7;

endpackage

// File: rtl/leb128_group.sv
// One LEB128 group: byte to emit, done flag and next remainder from the current remainder.
// Combinational, zero latency; no flow control of its own.
module leb128_group
  import leb128_pkg::*;
#(
  parameter int MAX_BYTES = 10
) (
  input  logic [63:0] rem,
  input  logic        is_signed,
  input  logic        is64,
  input  logic        pad,
  input  logic [3:0]  count,
  output logic [7:0]  group_byte,
  output logic        done,
  output logic [63:0] rem_next
);

  logic       nat_done;
  logic [3:0] pad_len;

  always_comb begin
    nat_done = 1'b0;
    pad_len  = 4'd0;
    done     = 1'b0;
    // Signed streams end when the remaining bits are pure sign extension of bit 6.
    if (is_signed)
      nat_done = ((rem[63:7] == '0) && !rem[6]) || ((&rem[63:7]) && rem[6]);
    else
      nat_done = (rem[63:7] == '0);
    pad_len = is64 ? 4'(LEB128_I64_MAX_BYTES) : 4'(LEB128_I32_MAX_BYTES);
    done    = pad ? (count >= pad_len) : nat_done;
    if ({28'd0, count} >= MAX_BYTES)
      done = 1'b1;
    group_byte = {~done, rem[6:0]};
    group_byte[LEB128_CONT_BIT] = ~done;
    rem_next   = {{7{is_signed & rem[63]}}, rem[63:7]};
  end

endmodule

// File: rtl/pack_i64.sv
// Sequential LEB128 encoder: first byte 1 cycle after accept, then 1 byte/handshake.
// Outputs hold while output_z_ack=0; input_a_ack only in IDLE. LEB128_PAD_EN adds input_pad.
module pack_i64
  import leb128_pkg::*;
#(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] input_a,
  input  logic        input_is64,
  input  logic        input_signed,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [7:0]  output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic        output_last,
  output logic [3:0]  output_len
`ifdef LEB128_PAD_EN
  ,
  input  logic        input_pad
`endif
);

  state_t      state, state_nxt;
  logic [63:0] rem, rem_nxt;
  logic        sgn, sgn_nxt;
  logic        is64, is64_nxt;
  logic        pad, pad_nxt;
  logic [3:0]  count, count_nxt;
  logic        pad_in;

  logic [7:0]  g_byte;
  logic        g_done;
  logic [63:0] g_rem_next;

`ifdef LEB128_PAD_EN
  assign pad_in = input_pad;
`else
  assign pad_in = 1'b0;
`endif

  leb128_group #(.MAX_BYTES(MAX_BYTES)) u_group (
    .rem        (rem),
    .is_signed  (sgn),
    .is64       (is64),
    .pad        (pad),
    .count      (count),
    .group_byte (g_byte),
    .done       (g_done),
    .rem_next   (g_rem_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      sgn   <= 1'b0;
      is64  <= 1'b0;
      pad   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      sgn   <= sgn_nxt;
      is64  <= is64_nxt;
      pad   <= pad_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sgn_nxt   = sgn;
    is64_nxt  = is64;
    pad_nxt   = pad;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (input_a_stb) begin
          // 32-bit values are widened here so the group logic only ever sees 64 bits.
          rem_nxt   = input_is64 ? input_a
                                 : {{32{input_signed & input_a[31]}}, input_a[31:0]};
          sgn_nxt   = input_signed;
          is64_nxt  = input_is64;
          pad_nxt   = pad_in;
          count_nxt = 4'd1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (output_z_ack) begin
          if (g_done) begin
            state_nxt = IDLE;
          end else begin
            rem_nxt   = g_rem_next;
            count_nxt = count + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    input_a_ack  = (state == IDLE);
    output_z_stb = (state == EMIT);
    output_z     = (state == EMIT) ? g_byte : 8'd0;
    output_last  = (state == EMIT) && g_done;
    output_len   = (state == EMIT) ? count : 4'd0;
  end

endmodule

// File: tb/tb_pack_i64.sv
// Directed-vector bench for the LEB128 encoder plus backpressure and reset sequences.
module tb_pack_i64;

  logic        clk;
  logic        reset;
  logic [63:0] input_a;
  logic        input_is64;
  logic        input_signed;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [7:0]  output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic        output_last;
  logic [3:0]  output_len;
`ifdef LEB128_PAD_EN
  logic        input_pad;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] a;
    logic        is64;
    logic        sgn;
    logic        pad;
    int          n;
    logic [79:0] b;   // first byte in b[7:0]
  } vec_t;

  vec_t vt[$];

  pack_i64 dut (
    .clk          (clk),
    .reset        (reset),
    .input_a      (input_a),
    .input_is64   (input_is64),
    .input_signed (input_signed),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .output_last  (output_last),
    .output_len   (output_len)
`ifdef LEB128_PAD_EN
    ,
    .input_pad    (input_pad)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the encoder idle; returns at the negedge where byte 1 shows.
  task automatic start(input logic [63:0] a, input logic is64, input logic sgn, input logic pad);
    input_a      = a;
    input_is64   = is64;
    input_signed = sgn;
`ifdef LEB128_PAD_EN
    input_pad    = pad;
`else
    if (pad) $display("pad request ignored in this build");
`endif
    input_a_stb  = 1'b1;
    @(negedge clk);
    input_a_stb  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] eb;
    output_z_ack = 1'b1;
    start(v.a, v.is64, v.sgn, v.pad);
    for (int k = 0; k < v.n; k++) begin
      eb = v.b[8*k +: 8];
      check($sformatf("vec%0d_byte%0d", idx, k),
            {50'd0, output_z_stb, output_last, output_len, output_z},
            {50'd0, 1'b1, (k == v.n - 1), 4'(k + 1), eb});
      @(negedge clk);
    end
    check($sformatf("vec%0d_idle", idx), {62'd0, output_z_stb, input_a_ack}, 64'd1);
  endtask

  initial begin
    reset        = 1'b1;
    input_a      = '0;
    input_is64   = 1'b0;
    input_signed = 1'b0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
`ifdef LEB128_PAD_EN
    input_pad    = 1'b0;
`endif

    vt.push_back('{a: 64'd624485,              is64: 1, sgn: 0, pad: 0, n: 3,  b: 80'h268EE5});
    vt.push_back('{a: 64'hFFFFFFFFFFFE1DC0,    is64: 1, sgn: 1, pad: 0, n: 3,  b: 80'h78BBC0});
    vt.push_back('{a: 64'h00000000FFFFFFFF,    is64: 0, sgn: 1, pad: 0, n: 1,  b: 80'h7F});
    vt.push_back('{a: 64'd64,                  is64: 1, sgn: 1, pad: 0, n: 2,  b: 80'h00C0});
    vt.push_back('{a: 64'hDEADBEEFFFFFFFFF,    is64: 0, sgn: 0, pad: 0, n: 5,  b: 80'h0FFFFFFFFF});
    vt.push_back('{a: 64'hFFFFFFFFFFFFFFFF,    is64: 1, sgn: 0, pad: 0, n: 10, b: 80'h01FFFFFFFFFFFFFFFFFF});
    vt.push_back('{a: 64'd0,                   is64: 1, sgn: 0, pad: 0, n: 1,  b: 80'h00});
    vt.push_back('{a: 64'd128,                 is64: 1, sgn: 0, pad: 0, n: 2,  b: 80'h0180});
    vt.push_back('{a: 64'hFFFFFFFFFFFFFFC0,    is64: 1, sgn: 1, pad: 0, n: 1,  b: 80'h40});
    vt.push_back('{a: 64'h8000000000000000,    is64: 1, sgn: 1, pad: 0, n: 10, b: 80'h7F808080808080808080});
    vt.push_back('{a: 64'h0000000080000000,    is64: 0, sgn: 1, pad: 0, n: 5,  b: 80'h7880808080});
    vt.push_back('{a: 64'd0,                   is64: 0, sgn: 0, pad: 0, n: 1,  b: 80'h00});
`ifdef LEB128_PAD_EN
    vt.push_back('{a: 64'd0,                   is64: 0, sgn: 0, pad: 1, n: 5,  b: 80'h0080808080});
    vt.push_back('{a: 64'h00000000FFFFFFFF,    is64: 0, sgn: 1, pad: 1, n: 5,  b: 80'h7FFFFFFFFF});
    vt.push_back('{a: 64'h00000000FFFFFFFF,    is64: 0, sgn: 1, pad: 0, n: 1,  b: 80'h7F});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {49'd0, input_a_ack, output_z_stb, output_last, output_len, output_z},
          {49'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});

    foreach (vt[i]) run_vec(vt[i], i);

    // Backpressure: 300 -> AC 02, ack low 3 cycles per byte, producer holding stb.
    output_z_ack = 1'b0;
    start(64'd300, 1'b1, 1'b0, 1'b0);
    input_a     = 64'h55;
    input_a_stb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        output_z_ack = (c == 3);
        if (k == 1 && c == 3) input_a_stb = 1'b0;
        check($sformatf("bp_byte%0d_c%0d", k, c),
              {50'd0, output_z_stb, output_last, output_len, output_z},
              {50'd0, 1'b1, (k == 1), 4'(k + 1), (k == 0) ? 8'hAC : 8'h02});
        check($sformatf("bp_iack%0d_c%0d", k, c), {63'd0, input_a_ack}, 64'd0);
        @(negedge clk);
      end
    end
    output_z_ack = 1'b0;
    check("bp_reaccept", {62'd0, output_z_stb, input_a_ack}, 64'd1);

    // Reset with ack while the second byte is pending: reset wins.
    output_z_ack = 1'b1;
    start(64'd624485, 1'b1, 1'b0, 1'b0);
    check("rst_b0", {56'd0, output_z}, 64'hE5);
    @(negedge clk);
    check("rst_b1", {56'd0, output_z}, 64'h8E);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_abort", {58'd0, input_a_ack, output_z_stb, output_len}, {58'd0, 1'b1, 1'b0, 4'd0});
    @(negedge clk);
    check("rst_quiet", {63'd0, output_z_stb}, 64'd0);
    run_vec('{a: 64'd0, is64: 1, sgn: 0, pad: 0, n: 1, b: 80'h00}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
